// File: rtl/merge_pipe_n.sv
// Pipelined Batcher odd-even merger: two sorted N-element key lists in,
// one sorted 2N-element list out. There is one register rank after every
// comparator layer. The order (ascending/descending) is chosen per batch,
// and the output has valid/ready backpressure.
module merge_pipe_n #(
    parameter int WIDTH = 3,
    parameter int N     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             load,
    input  logic [2*N*WIDTH-1:0]   inba,
    input  logic                   desc,
    output logic                   in_ready,
    output logic [2*N*WIDTH-1:0]   c,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int STAGES = $clog2(N) + 1;
    localparam int HW     = N * WIDTH;
    localparam int TW     = 2 * HW;

    // Input register: two halves, each with a full flag, plus the batch mode.
    logic [HW-1:0] a_q, a_d, b_q, b_d;
    logic          fa_q, fa_d, fb_q, fb_d;
    logic          mode_q, mode_d;

    // Rank s holds the result of comparator layer s.
    logic [TW-1:0]     rank_data_q [STAGES];
    logic [TW-1:0]     rank_data_d [STAGES];
    logic [STAGES-1:0] rank_valid_q, rank_valid_d;
    logic [STAGES-1:0] rank_mode_q, rank_mode_d;

    // Operands and results of each comparator layer.
    logic [TW-1:0]     layer_in  [STAGES];
    logic [TW-1:0]     layer_out [STAGES];
    logic [STAGES-1:0] layer_mode;

    logic stall_s, launch_s, acc_a_s, acc_b_s;

    // The comparator in layer s whose low end is element lo. The first layer
    // pairs i with i+N. Each later layer with distance k pairs the elements
    // that sit in odd k-blocks with their partner k above, if that partner
    // exists.
    function automatic logic pair_lo(input int s, input int lo);
        int k;
        k = N >> s;
        if (s == 0) begin
            pair_lo = (lo < N);
        end else begin
            pair_lo = (((lo / k) % 2) == 1) && ((lo + k) < 2 * N);
        end
    endfunction

    assign c         = rank_data_q[STAGES-1];
    assign out_valid = rank_valid_q[STAGES-1];

    // Handshake and launch decisions.
    always_comb begin
        stall_s  = rank_valid_q[STAGES-1] && !out_ready;
        in_ready = !(fa_q && fb_q && stall_s);
        acc_a_s  = load[0] && in_ready;
        acc_b_s  = load[1] && in_ready;
        launch_s = fa_q && fb_q && !stall_s;
    end

    // Input register update. A load on the launch edge keeps its flag set.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        fa_d   = fa_q;
        fb_d   = fb_q;
        mode_d = mode_q;
        if (acc_a_s) begin
            a_d  = inba[HW-1:0];
            fa_d = 1'b1;
        end else if (launch_s) begin
            fa_d = 1'b0;
        end else begin
            fa_d = fa_q;
        end
        if (acc_b_s) begin
            b_d  = inba[TW-1:HW];
            fb_d = 1'b1;
        end else if (launch_s) begin
            fb_d = 1'b0;
        end else begin
            fb_d = fb_q;
        end
        if (acc_a_s || acc_b_s) begin
            mode_d = desc;
        end else begin
            mode_d = mode_q;
        end
    end

    // Route the input register and the ranks to the comparator layers.
    always_comb begin
        layer_in[0] = {b_q, a_q};
        for (int s = 1; s < STAGES; s++) begin
            layer_in[s] = rank_data_q[s-1];
        end
        layer_mode = {rank_mode_q[STAGES-2:0], mode_q};
    end

    // Compare-exchange network. Ties never swap. In descending mode the low
    // position takes the larger key.
    always_comb begin
        logic [WIDTH-1:0] lo_v;
        logic [WIDTH-1:0] hi_v;
        logic             swap;
        int               hi;
        lo_v = {WIDTH{1'b0}};
        hi_v = {WIDTH{1'b0}};
        swap = 1'b0;
        hi   = 0;
        for (int s = 0; s < STAGES; s++) begin
            layer_out[s] = layer_in[s];
            for (int lo = 0; lo < 2 * N; lo++) begin
                hi = (lo + (N >> s)) % (2 * N);
                if (pair_lo(s, lo)) begin
                    lo_v = layer_in[s][lo*WIDTH +: WIDTH];
                    hi_v = layer_in[s][hi*WIDTH +: WIDTH];
                    swap = layer_mode[s] ? (lo_v < hi_v) : (lo_v > hi_v);
                    layer_out[s][lo*WIDTH +: WIDTH] = swap ? hi_v : lo_v;
                    layer_out[s][hi*WIDTH +: WIDTH] = swap ? lo_v : hi_v;
                end else begin
                    swap = 1'b0;
                end
            end
        end
    end

    // Rank advance. Bubbles move too; everything freezes while stalled.
    always_comb begin
        rank_data_d  = rank_data_q;
        rank_valid_d = rank_valid_q;
        rank_mode_d  = rank_mode_q;
        if (!stall_s) begin
            for (int s = 0; s < STAGES; s++) begin
                rank_data_d[s] = layer_out[s];
            end
            rank_valid_d = {rank_valid_q[STAGES-2:0], launch_s};
            rank_mode_d  = layer_mode;
        end else begin
            rank_valid_d = rank_valid_q;
            rank_mode_d  = rank_mode_q;
        end
    end

    // State registers. Reset discards every in-flight batch at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q          <= {HW{1'b0}};
            b_q          <= {HW{1'b0}};
            fa_q         <= 1'b0;
            fb_q         <= 1'b0;
            mode_q       <= 1'b0;
            rank_valid_q <= {STAGES{1'b0}};
            rank_mode_q  <= {STAGES{1'b0}};
            for (int s = 0; s < STAGES; s++) begin
                rank_data_q[s] <= {TW{1'b0}};
            end
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            fa_q         <= fa_d;
            fb_q         <= fb_d;
            mode_q       <= mode_d;
            rank_valid_q <= rank_valid_d;
            rank_mode_q  <= rank_mode_d;
            for (int s = 0; s < STAGES; s++) begin
                rank_data_q[s] <= rank_data_d[s];
            end
        end
    end

endmodule

// File: tb/tb_merge_pipe_n.sv
// Directed bench for merge_pipe_n with N=4 and WIDTH=3. It applies a table of
// merges with exact latency checks, then hand-written split-load, overwrite,
// backpressure and mid-flight reset sequences.
module tb_merge_pipe_n;
    logic        clk;
    logic        rst;
    logic [1:0]  load;
    logic [23:0] inba;
    logic        desc;
    logic        in_ready;
    logic [23:0] c;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        d;
        logic [23:0] e;
    } vec_t;

    vec_t        tv [8];
    int          bi [4];
    logic [23:0] bexp [4];
    int          got;

    merge_pipe_n #(.WIDTH(3), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .inba      (inba),
        .desc      (desc),
        .in_ready  (in_ready),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] p4(input int e0, input int e1, input int e2, input int e3);
        return {3'(e3), 3'(e2), 3'(e1), 3'(e0)};
    endfunction

    function automatic logic [23:0] p8(input int e0, input int e1, input int e2, input int e3,
                                       input int e4, input int e5, input int e6, input int e7);
        return {3'(e7), 3'(e6), 3'(e5), 3'(e4), 3'(e3), 3'(e2), 3'(e1), 3'(e0)};
    endfunction

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0] = '{p4(1,3,5,7), p4(0,2,4,6), 1'b0, p8(0,1,2,3,4,5,6,7)};
        tv[1] = '{p4(7,5,3,1), p4(6,4,2,0), 1'b1, p8(7,6,5,4,3,2,1,0)};
        tv[2] = '{p4(2,2,2,2), p4(2,2,2,2), 1'b0, p8(2,2,2,2,2,2,2,2)};
        tv[3] = '{p4(2,2,2,2), p4(2,2,2,2), 1'b1, p8(2,2,2,2,2,2,2,2)};
        tv[4] = '{p4(0,0,0,0), p4(7,7,7,7), 1'b0, p8(0,0,0,0,7,7,7,7)};
        tv[5] = '{p4(4,5,6,7), p4(0,1,2,3), 1'b0, p8(0,1,2,3,4,5,6,7)};
        tv[6] = '{p4(0,2,2,7), p4(1,1,3,6), 1'b0, p8(0,1,1,2,2,3,6,7)};
        tv[7] = '{p4(7,7,0,0), p4(5,4,4,1), 1'b1, p8(7,7,5,4,4,1,0,0)};

        rst = 1'b1; load = 2'b00; inba = 24'h0; desc = 1'b0; out_ready = 1'b1;
        #2;
        chk("reset_valid", 24'(out_valid), 24'h0);
        chk("reset_c", c, 24'h0);
        chk("reset_in_ready", 24'(in_ready), 24'h1);
        step(); step();
        rst = 1'b0;
        step();

        // Table: both halves loaded together, result exactly 3 edges later.
        for (int i = 0; i < 8; i++) begin
            load = 2'b11; inba = {tv[i].b, tv[i].a}; desc = tv[i].d; out_ready = 1'b1;
            step();
            load = 2'b00; inba = 24'h0; desc = ~tv[i].d;
            step(); chk("lat_e1", 24'(out_valid), 24'h0);
            step(); chk("lat_e2", 24'(out_valid), 24'h0);
            step(); chk("lat_e3", 24'(out_valid), 24'h1);
            chk($sformatf("merge_vec%0d", i), c, tv[i].e);
            step(); chk("drained", 24'(out_valid), 24'h0);
        end

        // Split load: A at edge 0 with desc=1, B at edge 5 with desc=0 (mode of last load wins).
        load = 2'b01; inba = {12'h000, p4(0,0,7,7)}; desc = 1'b1;
        step();
        load = 2'b00;
        for (int k = 0; k < 4; k++) begin
            step(); chk("split_wait", 24'(out_valid), 24'h0);
        end
        load = 2'b10; inba = {p4(1,2,3,4), 12'hfff}; desc = 1'b0;
        step();
        load = 2'b00;
        step(); chk("split_e6", 24'(out_valid), 24'h0);
        step(); chk("split_e7", 24'(out_valid), 24'h0);
        step(); chk("split_e8", 24'(out_valid), 24'h1);
        chk("split_c", c, p8(0,0,1,2,3,4,7,7));
        step(); chk("split_drain", 24'(out_valid), 24'h0);

        // Overwrite: A1 then A2 into the same half, then B.
        load = 2'b01; inba = {12'h000, p4(7,7,7,7)}; desc = 1'b0;
        step();
        inba = {12'h000, p4(0,1,2,3)};
        step();
        load = 2'b10; inba = {p4(4,5,6,7), p4(7,7,7,7)};
        step();
        load = 2'b00;
        step(); chk("ovw_e3", 24'(out_valid), 24'h0);
        step(); chk("ovw_e4", 24'(out_valid), 24'h0);
        step(); chk("ovw_e5", 24'(out_valid), 24'h1);
        chk("ovw_c", c, p8(0,1,2,3,4,5,6,7));
        step(); chk("ovw_single", 24'(out_valid), 24'h0);

        // Backpressure: four back-to-back batches, out_ready low for cycles 4..8.
        bi[0] = 0; bi[1] = 5; bi[2] = 6; bi[3] = 4;
        for (int i = 0; i < 4; i++) bexp[i] = tv[bi[i]].e;
        got = 0;
        for (int t = 0; t < 20; t++) begin
            load = (t < 4) ? 2'b11 : 2'b00;
            if (t < 4) begin
                inba = {tv[bi[t]].b, tv[bi[t]].a};
                desc = tv[bi[t]].d;
            end
            out_ready = (t >= 4 && t <= 8) ? 1'b0 : 1'b1;
            #1;
            if (t >= 4 && t <= 8) begin
                chk("bp_in_ready_low", 24'(in_ready), 24'h0);
                chk("bp_valid_held", 24'(out_valid), 24'h1);
                chk("bp_c_stable", c, bexp[0]);
            end
            if (t == 9) chk("bp_in_ready_high", 24'(in_ready), 24'h1);
            if (out_valid && out_ready) begin
                if (got < 4) chk($sformatf("bp_order%0d", got), c, bexp[got]);
                else chk("bp_extra", 24'(got), 24'h4);
                got++;
            end
            step();
        end
        chk("bp_count", 24'(got), 24'h4);

        // Reset one cycle after launch.
        load = 2'b11; inba = {tv[6].b, tv[6].a}; desc = 1'b0; out_ready = 1'b1;
        step();
        load = 2'b00;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 24'(out_valid), 24'h0);
        chk("rst_mid_c", c, 24'h0);
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(); chk("rst_no_stale", 24'(out_valid), 24'h0);
        end
        chk("rst_c_zero", c, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
